// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Instruction addresses are word aligned; low bits of a redirect are ignored.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hffff_fffc;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect inputs, imem handshake and IF/ID outputs.
interface fetch_unit_if;

  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] pcadd4_out;
  logic [31:0] inst_out;
  logic        commit_out;

  modport master (
    input  stall, br_taken, br_target, imem_ack, imem_rdata,
    output imem_req, imem_addr, pc_out, pcadd4_out, inst_out, commit_out
  );

  modport slave (
    output stall, br_taken, br_target, imem_ack, imem_rdata,
    input  imem_req, imem_addr, pc_out, pcadd4_out, inst_out, commit_out
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, handshakes with imem and buffers
// one instruction for IF/ID, discarding responses made stale by a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC
) (
  input logic           clk,
  input logic           rst,
  fetch_unit_if.master  fif
);
  import fetch_unit_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic         ob_valid_q, ob_valid_d;
  logic [31:0]  ob_pc_q, ob_pc_d;
  logic [31:0]  ob_inst_q, ob_inst_d;
  logic         accept;
  logic [31:0]  target;

  assign accept = ob_valid_q & ~fif.stall;
  assign target = align_pc(fif.br_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      fpc_q       <= RESET_PC;
      drop_addr_q <= RESET_PC;
      ob_valid_q  <= 1'b0;
      ob_pc_q     <= RESET_PC;
      ob_inst_q   <= NOP_INST;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      drop_addr_q <= drop_addr_d;
      ob_valid_q  <= ob_valid_d;
      ob_pc_q     <= ob_pc_d;
      ob_inst_q   <= ob_inst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    drop_addr_d = drop_addr_q;
    ob_valid_d  = ob_valid_q;
    ob_pc_d     = ob_pc_q;
    ob_inst_d   = ob_inst_q;

    if (accept) ob_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fif.br_taken) begin
          fpc_d   = target;
          state_d = REQ;
        end else if (!ob_valid_q || accept) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (fif.br_taken) begin
          fpc_d = target;
          // Without an ack the old request is still outstanding and must be drained.
          if (!fif.imem_ack) begin
            drop_addr_d = fpc_q;
            state_d     = DROP;
          end
        end else if (fif.imem_ack) begin
          ob_pc_d    = fpc_q;
          ob_inst_d  = fif.imem_rdata;
          ob_valid_d = 1'b1;
          fpc_d      = fpc_q + 32'd4;
          state_d    = IDLE;
        end
      end
      DROP: begin
        if (fif.br_taken) fpc_d = target;
        if (fif.imem_ack) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    if (fif.br_taken) ob_valid_d = 1'b0;
  end

  assign fif.imem_req   = (state_q == REQ) || (state_q == DROP);
  assign fif.imem_addr  = (state_q == DROP) ? drop_addr_q : fpc_q;
  assign fif.pc_out     = ob_pc_q;
  assign fif.pcadd4_out = ob_pc_q + 32'd4;
  assign fif.inst_out   = ob_valid_q ? ob_inst_q : NOP_INST;
  assign fif.commit_out = ob_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an imem responder with programmable latency
// feeds a scoreboard of instructions expected to appear on the IF/ID outputs.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk;
  logic rst;
  fetch_unit_if ifc();

  fetch_unit #(.RESET_PC(32'h1c00_0000)) dut (
    .clk (clk),
    .rst (rst),
    .fif (ifc.master)
  );

  int          compared;
  int          mismatched;
  int          cycleCnt;
  int          lastAckCycle;
  int          memLatency;
  int          reqAge;
  bit          stale;
  bit          drvRst;
  bit          drvStall;
  bit          drvBr;
  bit          drvSpurious;
  logic [31:0] drvTarget;
  logic [31:0] heldAddr;
  logic [15:0] commitHist;
  exp_t        sbQ[$];
  logic [31:0] reqLog[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // One cycle: sample outputs at the negedge, then drive inputs and play imem.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cycleCnt++;
    commitHist = {commitHist[14:0], ifc.commit_out};
    if (ifc.commit_out === 1'b1) begin
      if (sbQ.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL unexpected_commit: commit_out=1 pc_out=%h inst_out=%h, required no buffered instruction",
                 ifc.pc_out, ifc.inst_out);
      end else begin
        e = sbQ[0];
        compared++;
        if (ifc.pc_out !== e.pc) begin
          mismatched++;
          $display("[TB] FAIL sb_pc: got %h, expected %h", ifc.pc_out, e.pc);
        end
        compared++;
        if (ifc.pcadd4_out !== e.pc + 32'd4) begin
          mismatched++;
          $display("[TB] FAIL sb_pcadd4: got %h, expected %h", ifc.pcadd4_out, e.pc + 32'd4);
        end
        compared++;
        if (ifc.inst_out !== e.inst) begin
          mismatched++;
          $display("[TB] FAIL sb_inst: got %h, expected %h", ifc.inst_out, e.inst);
        end
      end
    end else begin
      compared++;
      if (ifc.inst_out !== 32'h0) begin
        mismatched++;
        $display("[TB] FAIL inst_when_invalid: got %h, expected 00000000", ifc.inst_out);
      end
    end

    rst            = drvRst;
    ifc.stall      = drvStall;
    ifc.br_taken   = drvBr;
    ifc.br_target  = drvTarget;
    ifc.imem_ack   = 1'b0;
    ifc.imem_rdata = 32'h0;

    if (drvRst) begin
      sbQ.delete();
      stale = 1'b0;
    end else if (ifc.commit_out === 1'b1 && sbQ.size() > 0 && (drvBr || !drvStall)) begin
      void'(sbQ.pop_front());
    end

    if (drvRst) begin
      reqAge = 0;
    end else if (ifc.imem_req === 1'b1) begin
      if (reqAge == 0) begin
        reqLog.push_back(ifc.imem_addr);
        heldAddr = ifc.imem_addr;
      end else begin
        compared++;
        if (ifc.imem_addr !== heldAddr) begin
          mismatched++;
          $display("[TB] FAIL addr_stable: got %h, expected %h", ifc.imem_addr, heldAddr);
        end
      end
      if (reqAge >= memLatency) begin
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = ~ifc.imem_addr;
        lastAckCycle   = cycleCnt;
        reqAge         = 0;
        if (stale) begin
          stale = 1'b0;
        end else if (!drvBr) begin
          e.pc   = ifc.imem_addr;
          e.inst = ~ifc.imem_addr;
          sbQ.push_back(e);
        end
      end else begin
        reqAge++;
        if (drvBr) stale = 1'b1;
      end
    end else begin
      reqAge = 0;
      if (drvSpurious) begin
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = 32'hdead_beef;
      end
    end
  endtask

  task automatic waitCommit(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (ifc.commit_out === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    drvRst = 1'b1;
    memLatency = 0;
    step();
    step();
    compared++;
    if (ifc.imem_req !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_req: got %b, expected 1", ifc.imem_req);
    end
    compared++;
    if (ifc.imem_addr !== 32'h1c00_0000) begin
      mismatched++; $display("[TB] FAIL reset_addr: got %h, expected 1c000000", ifc.imem_addr);
    end
    compared++;
    if (ifc.commit_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_commit: got %b, expected 0", ifc.commit_out);
    end
    compared++;
    if (ifc.pc_out !== 32'h1c00_0000) begin
      mismatched++; $display("[TB] FAIL reset_pc: got %h, expected 1c000000", ifc.pc_out);
    end
    compared++;
    if (ifc.pcadd4_out !== 32'h1c00_0004) begin
      mismatched++; $display("[TB] FAIL reset_pcadd4: got %h, expected 1c000004", ifc.pcadd4_out);
    end
    compared++;
    if (ifc.inst_out !== 32'h0) begin
      mismatched++; $display("[TB] FAIL reset_inst: got %h, expected 00000000", ifc.inst_out);
    end
    drvRst = 1'b0;
    reqLog.delete();
  endtask

  task automatic test_zero_wait();
    logic [31:0] expAddr;
    memLatency = 0;
    commitHist = '0;
    repeat (6) step();
    for (int i = 0; i < 3; i++) begin
      expAddr = 32'h1c00_0000 + 32'(4 * i);
      compared++;
      if (i >= reqLog.size()) begin
        mismatched++; $display("[TB] FAIL zw_addr%0d: no request seen, expected %h", i, expAddr);
      end else if (reqLog[i] !== expAddr) begin
        mismatched++; $display("[TB] FAIL zw_addr%0d: got %h, expected %h", i, reqLog[i], expAddr);
      end
    end
    compared++;
    if (commitHist[5:0] !== 6'b010101) begin
      mismatched++; $display("[TB] FAIL zw_commit_pattern: got %b, expected 010101", commitHist[5:0]);
    end
  endtask

  task automatic test_stall();
    int n;
    step();
    drvStall = 1'b1;
    drvSpurious = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      compared++;
      if (ifc.imem_req !== 1'b0) begin
        mismatched++; $display("[TB] FAIL stall_req%0d: got %b, expected 0", i, ifc.imem_req);
      end
    end
    drvStall = 1'b0;
    drvSpurious = 1'b0;
    step();
    n = reqLog.size();
    step();
    compared++;
    if (ifc.imem_req !== 1'b1 || reqLog.size() != n + 1) begin
      mismatched++; $display("[TB] FAIL stall_release_req: req=%b new_reqs=%0d, expected 1 and 1",
                             ifc.imem_req, reqLog.size() - n);
    end else if (reqLog[n] !== 32'h1c00_0010) begin
      mismatched++; $display("[TB] FAIL stall_release_addr: got %h, expected 1c000010", reqLog[n]);
    end
    step();
  endtask

  task automatic test_latency();
    bit found;
    memLatency = 3;
    waitCommit(20, found);
    compared++;
    if (!found) begin
      mismatched++; $display("[TB] FAIL lat_timeout: commit_out=0 after 20 cycles, expected 1");
    end else if (cycleCnt - lastAckCycle != 1) begin
      mismatched++; $display("[TB] FAIL lat_commit_delay: got %0d cycles, expected 1", cycleCnt - lastAckCycle);
    end
    compared++;
    if (reqLog[$] !== 32'h1c00_0014) begin
      mismatched++; $display("[TB] FAIL lat_addr: got %h, expected 1c000014", reqLog[$]);
    end
  endtask

  task automatic test_branch_req();
    bit found;
    memLatency = 2;
    drvBr = 1'b1;
    drvTarget = 32'h1c00_0100;
    step();
    drvBr = 1'b0;
    waitCommit(20, found);
    compared++;
    if (!found) begin
      mismatched++; $display("[TB] FAIL brq_timeout: commit_out=0 after 20 cycles, expected 1");
    end
    compared++;
    if (reqLog[$] !== 32'h1c00_0100) begin
      mismatched++; $display("[TB] FAIL brq_target_addr: got %h, expected 1c000100", reqLog[$]);
    end
    compared++;
    if (reqLog[reqLog.size() - 2] !== 32'h1c00_0018) begin
      mismatched++; $display("[TB] FAIL brq_stale_addr: got %h, expected 1c000018", reqLog[reqLog.size() - 2]);
    end
  endtask

  task automatic test_branch_ack_same();
    bit found;
    memLatency = 0;
    drvBr = 1'b1;
    drvTarget = 32'h1c00_0102;
    step();
    drvBr = 1'b0;
    step();
    compared++;
    if (ifc.commit_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL bra_commit: got %b, expected 0", ifc.commit_out);
    end
    compared++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h1c00_0100) begin
      mismatched++; $display("[TB] FAIL bra_target: req=%b addr=%h, expected 1 1c000100", ifc.imem_req, ifc.imem_addr);
    end
    waitCommit(10, found);
    compared++;
    if (!found) begin
      mismatched++; $display("[TB] FAIL bra_timeout: commit_out=0 after 10 cycles, expected 1");
    end
  endtask

  task automatic test_branch_stall();
    bit found;
    drvStall = 1'b1;
    waitCommit(10, found);
    drvBr = 1'b1;
    drvTarget = 32'h1c00_0200;
    step();
    drvBr = 1'b0;
    step();
    compared++;
    if (ifc.commit_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL brs_commit: got %b, expected 0", ifc.commit_out);
    end
    compared++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h1c00_0200) begin
      mismatched++; $display("[TB] FAIL brs_target: req=%b addr=%h, expected 1 1c000200", ifc.imem_req, ifc.imem_addr);
    end
    drvStall = 1'b0;
    waitCommit(10, found);
    compared++;
    if (!found) begin
      mismatched++; $display("[TB] FAIL brs_timeout: commit_out=0 after 10 cycles, expected 1");
    end
  endtask

  task automatic test_wrap();
    drvBr = 1'b1;
    drvTarget = 32'hffff_fffc;
    step();
    drvBr = 1'b0;
    step();
    step();
    compared++;
    if (ifc.commit_out !== 1'b1 || ifc.pc_out !== 32'hffff_fffc) begin
      mismatched++; $display("[TB] FAIL wrap_pc: commit=%b pc=%h, expected 1 fffffffc", ifc.commit_out, ifc.pc_out);
    end
    compared++;
    if (ifc.pcadd4_out !== 32'h0) begin
      mismatched++; $display("[TB] FAIL wrap_pcadd4: got %h, expected 00000000", ifc.pcadd4_out);
    end
    step();
    compared++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h0) begin
      mismatched++; $display("[TB] FAIL wrap_next_addr: req=%b addr=%h, expected 1 00000000", ifc.imem_req, ifc.imem_addr);
    end
  endtask

  task automatic test_reset_midwait();
    memLatency = 5;
    step();
    step();
    step();
    drvRst = 1'b1;
    step();
    drvRst = 1'b0;
    step();
    compared++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 32'h1c00_0000) begin
      mismatched++; $display("[TB] FAIL rstw_addr: req=%b addr=%h, expected 1 1c000000", ifc.imem_req, ifc.imem_addr);
    end
    compared++;
    if (ifc.commit_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL rstw_commit: got %b, expected 0", ifc.commit_out);
    end
    step();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    cycleCnt = 0;
    lastAckCycle = 0;
    reqAge = 0;
    stale = 1'b0;
    drvRst = 1'b1;
    drvStall = 1'b0;
    drvBr = 1'b0;
    drvSpurious = 1'b0;
    drvTarget = 32'h0;
    heldAddr = 32'h0;
    commitHist = '0;
    rst = 1'b1;
    ifc.stall = 1'b0;
    ifc.br_taken = 1'b0;
    ifc.br_target = 32'h0;
    ifc.imem_ack = 1'b0;
    ifc.imem_rdata = 32'h0;

    $display("[TB] starting fetch_unit bench");
    test_reset();
    test_zero_wait();
    test_stall();
    test_latency();
    test_branch_req();
    test_branch_ack_same();
    test_branch_stall();
    test_wrap();
    test_reset_midwait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
